// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 key expansion sequencer; optional round-key store under AES_KEY_STORE_EN
module aes_key_sched_ctrl #(
    parameter int NUM_RND = 10
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] key_i,
    output logic         busy,
    output logic         done,
    output logic         sbox_req,
    input  logic         sbox_gnt,
    output logic [31:0]  sbox_word_o,
    input  logic         sbox_vld,
    input  logic [31:0]  sbox_word_i,
    output logic [7:0]   rcon_o,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_idx
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         store_full
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_RND);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OUT,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic         rk_hs;

    assign {w0, w1, w2, w3} = key_q;

    // Next round key chain: each new word folds in the one just produced
    assign nw0 = w0 ^ sbox_word_i ^ {rcon_q, 24'h0};
    assign nw1 = w1 ^ nw0;
    assign nw2 = w2 ^ nw1;
    assign nw3 = w3 ^ nw2;

    // A handshake cancelled by abort does not count as delivery
    assign rk_hs = (state_q == ST_OUT) && rk_ready && !abort;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    // Sequencing: abort overrides every transition
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        key_d   = key_i;
                        idx_d   = 4'd0;
                        rcon_d  = 8'h01;
                        state_d = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (rk_ready) begin
                        if (idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (sbox_gnt) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sbox_vld) begin
                        key_d   = {nw0, nw1, nw2, nw3};
                        rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_OUT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign sbox_req    = (state_q == ST_REQ);
    assign sbox_word_o = (state_q == ST_REQ) ? {w3[23:0], w3[31:24]} : 32'h0;
    assign rcon_o      = rcon_q;
    assign rk_valid    = (state_q == ST_OUT);
    assign rk_o        = key_q;
    assign rk_idx      = idx_q;

`ifdef AES_KEY_STORE_EN
    logic [127:0] store_q [NUM_RND+1];
    logic         store_full_q;

    // Capture every delivered round key; contents survive start and abort
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i <= NUM_RND; i++) begin
                store_q[i] <= '0;
            end
            store_full_q <= 1'b0;
        end else begin
            if (rk_hs) begin
                store_q[idx_q] <= key_q;
            end
            if (abort || ((state_q == ST_IDLE) && start)) begin
                store_full_q <= 1'b0;
            end else if (rk_hs && (idx_q == LAST_IDX)) begin
                store_full_q <= 1'b1;
            end
        end
    end

    assign rk_rd_data = (rk_rd_idx <= LAST_IDX) ? store_q[rk_rd_idx] : '0;
    assign store_full = store_full_q;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [7:0] RCON_TAB [0:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 8'h6c};

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [127:0] key_i = '0;
    logic         busy, done, sbox_req;
    logic         sbox_gnt = 1'b0;
    logic [31:0]  sbox_word_o;
    logic         sbox_vld = 1'b0;
    logic [31:0]  sbox_word_i = '0;
    logic [7:0]   rcon_o;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_o;
    logic [3:0]   rk_idx;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rk_rd_idx = '0;
    logic [127:0] rk_rd_data;
    logic         store_full;
`endif

    aes_key_sched_ctrl #(.NUM_RND(10)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort), .key_i(key_i),
        .busy(busy), .done(done), .sbox_req(sbox_req), .sbox_gnt(sbox_gnt),
        .sbox_word_o(sbox_word_o), .sbox_vld(sbox_vld), .sbox_word_i(sbox_word_i),
        .rcon_o(rcon_o), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_o(rk_o),
        .rk_idx(rk_idx)
`ifdef AES_KEY_STORE_EN
        , .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data), .store_full(store_full)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        logic [7:0]   rcon;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] exp_keys [0:10];
    logic [127:0] got_key [0:10];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           hs_cnt = 0;
    int           gnt_dly = 0;
    int           vld_dly = 0;
    bit           vld_block = 1'b0;
    bit           rdy_rand = 1'b0;
    int           phase = 0;
    int           gcnt = 0;
    int           vcnt = 0;
    logic [31:0]  word_cap = '0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_idx = '0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic compute_keys(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {RCON_TAB[i/4 - 1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < 11; k++) begin
            e.idx = 4'(k);
            e.key = exp_keys[k];
            e.rcon = RCON_TAB[k];
            sb.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_stall) begin
            total++;
            if (rk_o !== prev_key || rk_idx !== prev_idx) begin
                bad++;
                $display("FAIL stall_hold: rk_idx=%0d rk_o=%h, required rk_idx=%0d rk_o=%h", rk_idx, rk_o, prev_idx, prev_key);
            end
        end
        if (phase == 0) begin
            sbox_vld = 1'b0;
            if (sbox_req === 1'b1) begin
                if (gcnt >= gnt_dly) begin
                    sbox_gnt = 1'b1;
                    word_cap = sbox_word_o;
                    phase = 1;
                    vcnt = 0;
                end else begin
                    sbox_gnt = 1'b0;
                    gcnt++;
                end
            end else begin
                sbox_gnt = 1'b0;
                gcnt = 0;
            end
        end else begin
            sbox_gnt = 1'b0;
            gcnt = 0;
            if (!vld_block && vcnt >= vld_dly) begin
                sbox_vld = 1'b1;
                sbox_word_i = subword(word_cap);
                phase = 0;
            end else begin
                sbox_vld = 1'b0;
                vcnt++;
            end
        end
        rk_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rk_valid === 1'b1 && rk_ready && !abort) begin
            hs_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got rk_idx=%0d rk_o=%h, required no delivery", rk_idx, rk_o);
            end else begin
                e = sb.pop_front();
                if (rk_idx !== e.idx || rk_o !== e.key) begin
                    bad++;
                    $display("FAIL rk_key: rk_idx=%0d rk_o=%h, required rk_idx=%0d rk_o=%h", rk_idx, rk_o, e.idx, e.key);
                end
                total++;
                if (rcon_o !== e.rcon) begin
                    bad++;
                    $display("FAIL rcon: rk_idx=%0d rcon_o=%h, required %h", rk_idx, rcon_o, e.rcon);
                end
            end
            if (rk_idx <= 4'd10) got_key[rk_idx] = rk_o;
        end
        prev_stall = (rk_valid === 1'b1) && !rk_ready && !abort;
        prev_key = rk_o;
        prev_idx = rk_idx;
    endtask

    task automatic run_job(input logic [127:0] key, input int gd, input int vd, input bit rr, input bit chk_lat);
        int s;
        int d0;
        compute_keys(key);
        push_expected();
        gnt_dly = gd;
        vld_dly = vd;
        rdy_rand = rr;
        vld_block = 1'b0;
        phase = 0;
        gcnt = 0;
        vcnt = 0;
        for (int r = 0; r < 11; r++) got_key[r] = '0;
        key_i = key;
        start = 1'b1;
        s = cyc;
        d0 = done_cnt;
        step();
        start = 1'b0;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) step();
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL done_timeout: done not seen, required within 4000 cycles");
        end else if (chk_lat) begin
            total++;
            if (done_cyc - s != 32 + 10 * (gd + vd)) begin
                bad++;
                $display("FAIL done_latency: %0d cycles, required %0d", done_cyc - s, 32 + 10 * (gd + vd));
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_left: %0d keys undelivered, required 0", sb.size());
        end
        sb.delete();
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sbox_req !== 1'b0 || rk_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_ctrl: busy=%b done=%b sbox_req=%b rk_valid=%b, required 0 0 0 0", tag, busy, done, sbox_req, rk_valid);
        end
        total++;
        if (rk_o !== 128'h0 || rk_idx !== 4'd0) begin
            bad++;
            $display("FAIL %s_rk: rk_o=%h rk_idx=%0d, required 0 0", tag, rk_o, rk_idx);
        end
        total++;
        if (rcon_o !== 8'h01 || sbox_word_o !== 32'h0) begin
            bad++;
            $display("FAIL %s_rcon_word: rcon_o=%h sbox_word_o=%h, required 01 0", tag, rcon_o, sbox_word_o);
        end
`ifdef AES_KEY_STORE_EN
        total++;
        if (store_full !== 1'b0) begin
            bad++;
            $display("FAIL %s_store_full: %b, required 0", tag, store_full);
        end
`endif
    endtask

    task automatic test_reset();
        step();
        step();
        check_reset_values("reset");
        nrst = 1'b1;
        step();
        check_reset_values("post_reset");
    endtask

    task automatic test_fips();
        run_job(FIPS_KEY, 0, 0, 1'b0, 1'b1);
        total++;
        if (got_key[1] !== FIPS_RK1) begin
            bad++;
            $display("FAIL fips_rk1: %h, required %h", got_key[1], FIPS_RK1);
        end
        total++;
        if (got_key[10] !== FIPS_RK10) begin
            bad++;
            $display("FAIL fips_rk10: %h, required %h", got_key[10], FIPS_RK10);
        end
`ifdef AES_KEY_STORE_EN
        total++;
        if (store_full !== 1'b1) begin
            bad++;
            $display("FAIL store_full_set: %b, required 1", store_full);
        end
        rk_rd_idx = 4'd10;
        #1;
        total++;
        if (rk_rd_data !== FIPS_RK10) begin
            bad++;
            $display("FAIL store_rd10: %h, required %h", rk_rd_data, FIPS_RK10);
        end
        rk_rd_idx = 4'd12;
        #1;
        total++;
        if (rk_rd_data !== 128'h0) begin
            bad++;
            $display("FAIL store_rd12: %h, required 0", rk_rd_data);
        end
        rk_rd_idx = 4'd0;
        #1;
        total++;
        if (rk_rd_data !== FIPS_KEY) begin
            bad++;
            $display("FAIL store_rd0: %h, required %h", rk_rd_data, FIPS_KEY);
        end
`endif
    endtask

    task automatic test_delayed();
        run_job(FIPS_KEY, 3, 2, 1'b0, 1'b1);
        total++;
        if (got_key[10] !== FIPS_RK10) begin
            bad++;
            $display("FAIL delayed_rk10: %h, required %h", got_key[10], FIPS_RK10);
        end
    endtask

    task automatic test_ready_random();
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1, 1'b1, 1'b0);
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 2, 0, 1'b1, 1'b0);
    endtask

    task automatic test_abort();
        int d0;
        int hs0;
        int i;
        compute_keys(FIPS_KEY);
        push_expected();
        gnt_dly = 0;
        vld_dly = 0;
        rdy_rand = 1'b0;
        vld_block = 1'b0;
        phase = 0;
        d0 = done_cnt;
        hs0 = hs_cnt;
        key_i = FIPS_KEY;
        start = 1'b1;
        step();
        start = 1'b0;
        for (i = 0; i < 200 && !(rk_idx == 4'd4 && sbox_req === 1'b1); i++) step();
        total++;
        if (i >= 200) begin
            bad++;
            $display("FAIL abort_reach: round 4 request not seen, required within 200 cycles");
        end
        vld_block = 1'b1;
        step();
        total++;
        if (busy !== 1'b1 || sbox_req !== 1'b0 || rk_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_wait: busy=%b sbox_req=%b rk_valid=%b, required 1 0 0", busy, sbox_req, rk_valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || sbox_req !== 1'b0 || rk_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: busy=%b sbox_req=%b rk_valid=%b, required 0 0 0", busy, sbox_req, rk_valid);
        end
        vld_block = 1'b0;
        step();
        step();
        total++;
        if (rk_idx !== 4'd4 || rk_o !== exp_keys[4] || rcon_o !== 8'h10) begin
            bad++;
            $display("FAIL late_vld: rk_idx=%0d rk_o=%h rcon_o=%h, required 4 %h 10", rk_idx, rk_o, rcon_o, exp_keys[4]);
        end
        total++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_done: done pulses=%0d busy=%b, required 0 0", done_cnt - d0, busy);
        end
        total++;
        if (hs_cnt - hs0 != 5) begin
            bad++;
            $display("FAIL abort_hs_count: %0d deliveries, required 5", hs_cnt - hs0);
        end
        sb.delete();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_abort: busy=%b, required 0", busy);
        end
        run_job(FIPS_KEY, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int i;
        compute_keys(FIPS_KEY);
        push_expected();
        gnt_dly = 1000;
        vld_dly = 0;
        rdy_rand = 1'b0;
        phase = 0;
        gcnt = 0;
        key_i = FIPS_KEY;
        start = 1'b1;
        step();
        start = 1'b0;
        for (i = 0; i < 20 && sbox_req !== 1'b1; i++) step();
        total++;
        if (sbox_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_reach_req: sbox_req=%b, required 1", sbox_req);
        end
        #1;
        nrst = 1'b0;
        #1;
        check_reset_values("rst_mid");
        step();
        nrst = 1'b1;
        sb.delete();
        gnt_dly = 0;
        step();
        check_reset_values("rst_mid_rel");
    endtask

    task automatic test_back_to_back();
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 1, 0, 1'b0, 1'b1);
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 3, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fips();
        test_delayed();
        test_ready_random();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
